// File: rtl/fb_pixel_fetcher_if.sv
// Pixel-side and framebuffer-side signals of fb_pixel_fetcher.
// master = the fetcher, slave = the display core plus framebuffer RAM.
interface fb_pixel_fetcher_if #(
    parameter int ADDR_W = 15
);
    logic              i_frame_start;
    logic              i_fetch_next_pixel;
    logic [2:0]        o_pixel_rgb;
    logic              o_pixel_valid;
    logic              o_fb_rd_en;
    logic [ADDR_W-1:0] o_fb_rd_addr;
    logic [2:0]        i_fb_rd_data;
    logic              o_underflow;

    modport master (
        input  i_frame_start, i_fetch_next_pixel, i_fb_rd_data,
        output o_pixel_rgb, o_pixel_valid, o_fb_rd_en, o_fb_rd_addr, o_underflow
    );

    modport slave (
        output i_frame_start, i_fetch_next_pixel, i_fb_rd_data,
        input  o_pixel_rgb, o_pixel_valid, o_fb_rd_en, o_fb_rd_addr, o_underflow
    );
endinterface

// File: rtl/fb_pixel_fetcher.sv
// Scaled framebuffer reader feeding a show-ahead FIFO of pixels in raster order.
// Latency: first read 1 cycle after frame_start, head valid 2 cycles later; reads stall on FIFO credit.
module fb_pixel_fetcher #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset_,
    fb_pixel_fetcher_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] FB_W   = ADDR_W'(H_PIXELS >> SCALE_SHIFT);
    localparam logic [9:0]        X_LAST = 10'(H_PIXELS - 1);
    localparam logic [8:0]        Y_LAST = 9'(V_LINES - 1);
    localparam logic [8:0]        Y_MASK = 9'((1 << SCALE_SHIFT) - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state;
    logic [9:0]        x;
    logic [8:0]        y;
    logic [ADDR_W-1:0] line_base;
    logic              rd_pending;
    logic              underflow_q;
    logic [2:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [2:0]        head_nxt;
    logic              flush, issue, push, pop, starve;

    always_comb begin
        flush  = bus.i_frame_start;
        // Credit counts the in-flight read; a same-cycle pop is deliberately not credited.
        issue  = (state == STREAM) && ((count + CNT_W'(rd_pending)) < CNT_W'(FIFO_DEPTH)) && !flush;
        push   = rd_pending && !flush;
        pop    = bus.i_fetch_next_pixel && (count != '0) && !flush;
        starve = bus.i_fetch_next_pixel && (count == '0) && !flush;
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        head_nxt   = 3'b000;
        if (count_nxt != '0) begin
            // Only the incoming word can become head when nothing else survives the pop.
            if ((count - CNT_W'(pop)) == '0)
                head_nxt = bus.i_fb_rd_data;
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    assign bus.o_fb_rd_en   = issue;
    assign bus.o_fb_rd_addr = line_base + ADDR_W'(x >> SCALE_SHIFT);
    assign bus.o_underflow  = underflow_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.i_fb_rd_data;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state             <= IDLE;
            x                 <= '0;
            y                 <= '0;
            line_base         <= '0;
            rd_pending        <= 1'b0;
            underflow_q       <= 1'b0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            bus.o_pixel_rgb   <= 3'b000;
            bus.o_pixel_valid <= 1'b0;
        end else if (flush) begin
            state             <= STREAM;
            x                 <= '0;
            y                 <= '0;
            line_base         <= '0;
            rd_pending        <= 1'b0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            bus.o_pixel_rgb   <= 3'b000;
            bus.o_pixel_valid <= 1'b0;
        end else begin
            rd_pending        <= issue;
            if (starve)
                underflow_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr            <= rd_ptr_nxt;
            count             <= count_nxt;
            bus.o_pixel_valid <= (count_nxt != '0);
            bus.o_pixel_rgb   <= head_nxt;
            if (issue) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? 9'd0 : y + 9'd1;
                    // Advance one framebuffer row after each group of replicated lines.
                    if ((y & Y_MASK) == Y_MASK)
                        line_base <= line_base + FB_W;
                    if (y == Y_LAST)
                        state <= DONE;
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_pixel_fetcher.sv
// Directed bench for fb_pixel_fetcher on a reduced 64x32 raster (16x8 framebuffer)
// so whole frames fit in a short run; RAM model returns addr[2:0].
module tb_fb_pixel_fetcher;
    localparam int H  = 64;
    localparam int V  = 32;
    localparam int S  = 2;
    localparam int AW = 15;
    localparam int D  = 4;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic reset_;
    int total = 0;
    int bad   = 0;

    fb_pixel_fetcher_if #(.ADDR_W(AW)) bus ();

    fb_pixel_fetcher #(
        .H_PIXELS(H), .V_LINES(V), .SCALE_SHIFT(S), .ADDR_W(AW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset_(reset_), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.o_fb_rd_en) bus.i_fb_rd_data <= bus.o_fb_rd_addr[2:0];

    int   rd_q[$];
    int   pop_q[$];
    logic s_rd_en, s_valid, s_uf;
    int   s_addr, s_rgb;

    function automatic int exp_addr(int i);
        int xx = i % H;
        int yy = i / H;
        return (yy / (1 << S)) * (H / (1 << S)) + xx / (1 << S);
    endfunction

    function automatic int exp_pix(int i);
        return exp_addr(i) % 8;
    endfunction

    function automatic int rd_at(int i);
        if (i < rd_q.size()) return rd_q[i];
        return -1;
    endfunction

    function automatic int pop_at(int i);
        if (i < pop_q.size()) return pop_q[i];
        return -1;
    endfunction

    // Called at a negedge: drive inputs for the next posedge, sample, log, advance.
    task automatic step(input logic fs, input logic pop);
        bus.i_frame_start      = fs;
        bus.i_fetch_next_pixel = pop;
        #1;
        s_rd_en = bus.o_fb_rd_en;
        s_addr  = int'(bus.o_fb_rd_addr);
        s_valid = bus.o_pixel_valid;
        s_rgb   = int'(bus.o_pixel_rgb);
        s_uf    = bus.o_underflow;
        if (s_rd_en) rd_q.push_back(s_addr);
        if (pop && s_valid && !fs) pop_q.push_back(s_rgb);
        @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        reset_ = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_fetch_next_pixel = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.o_pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.o_pixel_valid); end
        total++; if (bus.o_pixel_rgb !== 3'b000) begin bad++; $display("FAIL rst_rgb: got %b want 000", bus.o_pixel_rgb); end
        total++; if (bus.o_fb_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", bus.o_fb_rd_en); end
        total++; if (bus.o_fb_rd_addr !== '0) begin bad++; $display("FAIL rst_addr: got %0d want 0", bus.o_fb_rd_addr); end
        total++; if (bus.o_underflow !== 1'b0) begin bad++; $display("FAIL rst_underflow: got %b want 0", bus.o_underflow); end
        @(negedge clk);
        reset_ = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0);
            if (s_rd_en) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL idle_reads: got %0d want 0", n); end
    endtask

    task automatic test_fill;
        int mask, first_valid, nz;
        rd_q.delete();
        mask = 0; first_valid = -1; nz = 0;
        step(1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0);
            if (s_rd_en) mask |= (1 << (k - 1));
            if (s_valid && first_valid < 0) first_valid = k;
        end
        foreach (rd_q[i]) if (rd_q[i] != 0) nz++;
        total++; if (rd_q.size() != 4) begin bad++; $display("FAIL fill_reads: got %0d want 4", rd_q.size()); end
        total++; if (mask != 'hF) begin bad++; $display("FAIL fill_read_cycles: got %h want f", mask); end
        total++; if (nz != 0) begin bad++; $display("FAIL fill_addr: got %0d nonzero want 0", nz); end
        total++; if (first_valid != 3) begin bad++; $display("FAIL fill_valid_latency: got %0d want 3", first_valid); end
    endtask

    task automatic run_frame;
        rd_q.delete();
        pop_q.delete();
        step(1'b1, 1'b0);
        for (int c = 0; c < NPIX + 200; c++) step(1'b0, bus.o_pixel_valid);
    endtask

    task automatic test_address_sequence;
        int mm;
        run_frame();
        mm = 0;
        for (int i = 0; i < NPIX; i++) if (rd_at(i) != exp_addr(i)) mm++;
        total++; if (rd_q.size() != NPIX) begin bad++; $display("FAIL addr_total_reads: got %0d want %0d", rd_q.size(), NPIX); end
        total++; if (rd_at(3) != 0) begin bad++; $display("FAIL addr_x3: got %0d want 0", rd_at(3)); end
        total++; if (rd_at(4) != 1) begin bad++; $display("FAIL addr_x4: got %0d want 1", rd_at(4)); end
        total++; if (rd_at(H - 1) != 15) begin bad++; $display("FAIL addr_xlast: got %0d want 15", rd_at(H - 1)); end
        total++; if (rd_at(3 * H) != 0) begin bad++; $display("FAIL addr_y3: got %0d want 0", rd_at(3 * H)); end
        total++; if (rd_at(4 * H) != 16) begin bad++; $display("FAIL addr_y4: got %0d want 16", rd_at(4 * H)); end
        total++; if (rd_at(NPIX - 1) != 127) begin bad++; $display("FAIL addr_last: got %0d want 127", rd_at(NPIX - 1)); end
        total++; if (mm != 0) begin bad++; $display("FAIL addr_sequence: got %0d mismatches want 0", mm); end
    endtask

    task automatic test_continuous_frame;
        int mm;
        run_frame();
        mm = 0;
        for (int i = 0; i < NPIX; i++) if (pop_at(i) != exp_pix(i)) mm++;
        total++; if (pop_q.size() != NPIX) begin bad++; $display("FAIL cont_pops: got %0d want %0d", pop_q.size(), NPIX); end
        total++; if (mm != 0) begin bad++; $display("FAIL cont_data: got %0d mismatches want 0", mm); end
        total++; if (s_uf !== 1'b0) begin bad++; $display("FAIL cont_underflow: got %b want 0", s_uf); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL cont_drained: got %b want 0", s_valid); end
    endtask

    task automatic test_underflow;
        int mm;
        rd_q.delete();
        pop_q.delete();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        total++; if (s_uf !== 1'b1) begin bad++; $display("FAIL uf_set: got %b want 1", s_uf); end
        repeat (6) step(1'b0, 1'b0);
        total++; if (s_uf !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", s_uf); end
        total++; if (rd_q.size() != 4) begin bad++; $display("FAIL uf_no_pop: got %0d reads want 4", rd_q.size()); end
        repeat (12) step(1'b0, bus.o_pixel_valid);
        mm = 0;
        for (int i = 0; i < 8; i++) if (pop_at(i) != exp_pix(i)) mm++;
        total++; if (mm != 0) begin bad++; $display("FAIL uf_order: got %0d mismatches want 0", mm); end
    endtask

    task automatic test_reset_midframe;
        int n;
        repeat (5) step(1'b0, bus.o_pixel_valid);
        bus.i_fetch_next_pixel = 1'b1;
        #2 reset_ = 1'b0;
        #1;
        total++; if (bus.o_pixel_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.o_pixel_valid); end
        total++; if (bus.o_pixel_rgb !== 3'b000) begin bad++; $display("FAIL mid_rst_rgb: got %b want 000", bus.o_pixel_rgb); end
        total++; if (bus.o_fb_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_en: got %b want 0", bus.o_fb_rd_en); end
        total++; if (bus.o_fb_rd_addr !== '0) begin bad++; $display("FAIL mid_rst_addr: got %0d want 0", bus.o_fb_rd_addr); end
        total++; if (bus.o_underflow !== 1'b0) begin bad++; $display("FAIL mid_rst_underflow: got %b want 0", bus.o_underflow); end
        @(negedge clk);
        reset_ = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            if (s_rd_en || s_valid) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL mid_rst_idle: got %0d active cycles want 0", n); end
    endtask

    task automatic test_flush;
        logic hit;
        int mm;
        rd_q.delete();
        hit = 1'b0;
        step(1'b1, 1'b0);
        for (int c = 0; c < 1500 && !hit; c++) begin
            step(1'b0, bus.o_pixel_valid);
            if (s_rd_en && s_addr == 57) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL flush_reach57: got no read at 57 want one");
        end else begin
            total++; if (bus.o_pixel_valid !== 1'b1) begin bad++; $display("FAIL flush_pop_head: got %b want 1", bus.o_pixel_valid); end
            pop_q.delete();
            step(1'b1, 1'b1);
            total++; if (s_rd_en !== 1'b0) begin bad++; $display("FAIL flush_no_read: got %b want 0", s_rd_en); end
            step(1'b0, bus.o_pixel_valid);
            total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", s_valid); end
            total++; if (s_rd_en !== 1'b1) begin bad++; $display("FAIL flush_restart_rd: got %b want 1", s_rd_en); end
            total++; if (s_addr != 0) begin bad++; $display("FAIL flush_restart_addr: got %0d want 0", s_addr); end
            repeat (10) step(1'b0, bus.o_pixel_valid);
            mm = 0;
            for (int i = 0; i < 5; i++) if (pop_at(i) != exp_pix(i)) mm++;
            total++; if (mm != 0) begin bad++; $display("FAIL flush_data: got %0d mismatches want 0", mm); end
            total++; if (s_uf !== 1'b0) begin bad++; $display("FAIL flush_underflow: got %b want 0", s_uf); end
        end
    endtask

    initial begin
        bus.i_frame_start = 1'b0;
        bus.i_fetch_next_pixel = 1'b0;
        test_reset();
        test_fill();
        test_address_sequence();
        test_continuous_frame();
        test_underflow();
        test_reset_midframe();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_pixel_fetcher.md
# fb_pixel_fetcher

Framebuffer-backed pixel source for `vga_driver`, running in the 25 MHz pixel domain and sitting directly upstream of the core's `i_pixel_r/g/b` / `o_fetch_next_pixel` pair. It replaces the hard-coded pattern ROM with a scaled framebuffer reader. It walks the visible raster in screen order and issues reads to a synchronous 1-cycle-latency framebuffer RAM. A small show-ahead FIFO hides the RAM latency so the core sees the next pixel immediately whenever it pops.

## Interface
Parameters:
- `H_PIXELS`, 640, visible pixels per line
- `V_LINES`, 480, visible lines per frame
- `SCALE_SHIFT`, 2, log2 of the pixel replication factor in each axis; framebuffer is `(H_PIXELS>>SCALE_SHIFT) x (V_LINES>>SCALE_SHIFT)` (160x120 by default)
- `ADDR_W`, 15, framebuffer address width; must cover `FB_W*FB_H-1` (19199 by default)
- `FIFO_DEPTH`, 4, prefetch FIFO entries (power of 2, at least 2)

Ports (clock and reset first):
- `clk`  in  1  pixel clock (25 MHz)
- `reset_`  in  1  asynchronous, active-low reset
- `i_frame_start`  in  1  single-cycle pulse that restarts the raster at (0,0) and flushes buffered pixels
- `i_fetch_next_pixel`  in  1  pop request from `vga_driver`
- `o_pixel_rgb`  out  3  FIFO head pixel {r,g,b}; 3'b000 when the FIFO is empty
- `o_pixel_valid`  out  1  FIFO non-empty
- `o_fb_rd_en`  out  1  framebuffer read strobe
- `o_fb_rd_addr`  out  ADDR_W  framebuffer read address
- `i_fb_rd_data`  in  3  read data, valid exactly 1 cycle after `o_fb_rd_en`
- `o_underflow`  out  1  sticky flag: pop requested while the FIFO was empty

## Operation
- Derived constant: `FB_W = H_PIXELS>>SCALE_SHIFT`.
- State machine, three states:
  - IDLE (state after reset): no reads issued.
  - STREAM: reads issued.
  - DONE: all `H_PIXELS*V_LINES` reads for the frame issued; FIFO drains and no further reads are issued.
- `i_frame_start` moves any state to STREAM and performs a flush (below). STREAM moves to DONE when the read for screen (H_PIXELS-1, V_LINES-1) is issued.
- Raster counters:
  - `x` is 10 bits, counting 0..H_PIXELS-1; `y` is 9 bits, counting 0..V_LINES-1. Both advance once per issued read.
  - `x` wraps to 0 and increments `y`.
- Address generation uses no multiplier:
  - `o_fb_rd_addr = line_base + (x>>SCALE_SHIFT)`.
  - `line_base` starts at 0 and increases by `FB_W` whenever `y` wraps past a multiple of `2^SCALE_SHIFT`, i.e. when the low SCALE_SHIFT bits of `y` roll from all-ones to 0.
- Read issue condition: state STREAM, `count + rd_pending < FIFO_DEPTH`, and `i_frame_start` low.
  - `rd_pending` is set by `o_fb_rd_en` and cleared the next cycle.
  - A same-cycle pop is not credited.
- FIFO write: when `rd_pending` is 1, `i_fb_rd_data` is pushed that cycle.
- Pop: when `i_fetch_next_pixel` is 1 and the FIFO is non-empty, the head is removed.
- Underflow: `i_fetch_next_pixel` with an empty FIFO sets `o_underflow`, pops nothing and leaves counters unchanged. `o_underflow` clears only on reset.
- Flush on `i_frame_start`:
  - FIFO emptied, `x`, `y` and `line_base` cleared.
  - `rd_pending` is cleared, so the data of a read in flight is discarded and not pushed.
  - A pop in the same cycle is ignored (`i_frame_start` wins); no underflow is flagged that cycle.
- Push and pop in the same cycle leave `count` unchanged; a push never overflows, by the issue condition.

## Timing
- Reset (asynchronous assert, values held while `reset_`=0):
  - state IDLE
  - `o_pixel_rgb`=3'b000, `o_pixel_valid`=0, `o_fb_rd_en`=0, `o_fb_rd_addr`=0, `o_underflow`=0
  - FIFO empty, `rd_pending`=0, all counters 0
- `i_frame_start` sampled at edge E0:
  - first `o_fb_rd_en` in the cycle after E0, with address 0;
  - data pushed on the following edge, so `o_pixel_valid`=1 two cycles after the first read.
- Steady state: one read per cycle while the FIFO has room; pop-to-refill latency is 2 cycles.
- `o_pixel_rgb` and `o_pixel_valid` are registered FIFO-head outputs with no combinational path from `i_fetch_next_pixel`.
- Reset asserted mid-frame returns all state to the reset values immediately, with no partial pushes.

## Test plan
- Reset check: hold `reset_`=0 while driving `i_fetch_next_pixel`=1 -> all outputs stay at their reset values; after release with no `i_frame_start`, `o_fb_rd_en` stays 0.
- Fill latency: pulse `i_frame_start` with no pops -> exactly 4 reads at addresses 0,0,0,0, then `o_fb_rd_en` stays 0; `o_pixel_valid` rises 3 cycles after the frame_start edge.
- Address sequence: pop every cycle from a RAM model returning addr[2:0].
  - Screen x=0..3 read address 0, x=4 address 1, x=639 address 159.
  - Line y=3 restarts at address 0; y=4 starts at address 160.
  - Last read (639,479) is address 19199, then state DONE and reads stop.
- Underflow: pop immediately after `i_frame_start` -> `o_underflow`=1 and held, no pop occurs, and the later pixel order is unchanged.
- Mid-stream flush: pulse `i_frame_start` in the same cycle as a pop and an in-flight read at address 57 -> the stale data is not pushed, `o_pixel_valid`=0 the next cycle, and the next read is issued at address 0.
- Continuous frame: pop at 1 pixel/cycle for the full 640x480 -> no underflow, 307200 pops, and the data matches the scaled image model.
